// File: rtl/mips_pkg.sv
// Opcode constants, decode helpers and the MEM/WB latch layout shared by the pipeline stages.
// Pure declarations; no logic or timing of its own.
package mips_pkg;

  localparam logic [5:0] OP_LW    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b100001;
  localparam logic [5:0] OP_BEQZ  = 6'b110100;
  localparam logic [5:0] OP_BNEQZ = 6'b110101;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef struct packed {
    logic        valid;
    logic [31:0] npc;
    logic [31:0] ir;
    logic [31:0] alu;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic        is_load;
  } memwb_t;

  function automatic logic is_alu_rr(input logic [5:0] op);
    return op[5:4] == 2'b00;
  endfunction

  function automatic logic is_alu_ri(input logic [5:0] op);
    return op[5:4] == 2'b01;
  endfunction

  function automatic logic [4:0] dest_reg(input logic [31:0] ir);
    logic [5:0] op;
    op = ir[31:26];
    if (is_alu_rr(op))                    return ir[15:11];
    else if (is_alu_ri(op) || op == OP_LW) return ir[20:16];
    else                                   return 5'd0;
  endfunction

  // Only ALU ops and loads write back, and never to r0.
  function automatic logic writes_reg(input logic [31:0] ir);
    logic [5:0] op;
    op = ir[31:26];
    if (op inside {OP_SW, OP_BEQZ, OP_BNEQZ, OP_HLT}) return 1'b0;
    return dest_reg(ir) != 5'd0;
  endfunction

endpackage

// File: rtl/dmem.sv
// Word-addressed data memory: one synchronous write/registered-read port plus async debug read.
// Latency: read data valid after the edge where re is high; writes visible on dbg_data after their edge.
// Backpressure: none; the caller gates we/re.
module dmem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory access, write-back decode, MEM/WB latch and sticky halt flag.
// Latency: one cycle from an accepted EXE instruction to all outputs.
// Backpressure: stall freezes the latch and blocks stores; EXE must hold its values.
module mem_stage
  import mips_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          stall,
  input  logic [31:0]   NPC_ex,
  input  logic [31:0]   IR_ex,
  input  logic [31:0]   ALU_res,
  input  logic [31:0]   B_ex,
  output logic          valid_mem,
  output logic [31:0]   NPC_mem,
  output logic [31:0]   IR_mem,
  output logic [31:0]   ALU_mem,
  output logic [31:0]   LMD,
  output logic          wb_en,
  output logic [4:0]    wb_rd,
  output logic          halted,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  memwb_t      q;
  logic        halted_q;
  logic [5:0]  opcode;
  logic        accept;
  logic [31:0] rd_data;

  assign opcode = IR_ex[31:26];
  assign accept = in_valid & ~stall & ~halted_q & ~rst;

  dmem #(.AW(AW)) u_dmem (
    .clk      (clk),
    .we       (accept && opcode == OP_SW),
    .re       (accept && opcode == OP_LW),
    .addr     (ALU_res[AW-1:0]),
    .wdata    (B_ex),
    .rdata    (rd_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      halted_q <= 1'b0;
    end else if (!stall) begin
      if (halted_q || !in_valid) begin
        q.valid   <= 1'b0;
        q.wb_en   <= 1'b0;
        q.is_load <= 1'b0;
      end else begin
        q.valid   <= 1'b1;
        q.npc     <= NPC_ex;
        q.ir      <= IR_ex;
        q.alu     <= ALU_res;
        q.wb_en   <= writes_reg(IR_ex);
        q.wb_rd   <= dest_reg(IR_ex);
        q.is_load <= (opcode == OP_LW);
        if (opcode == OP_HLT) halted_q <= 1'b1;
      end
    end
  end

  // The RAM read register is not reset; is_load masks it so LMD is 0 out of reset and for non-loads.
  assign LMD       = q.is_load ? rd_data : 32'd0;
  assign valid_mem = q.valid;
  assign NPC_mem   = q.npc;
  assign IR_mem    = q.ir;
  assign ALU_mem   = q.alu;
  assign wb_en     = q.wb_en;
  assign wb_rd     = q.wb_rd;
  assign halted    = halted_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand sequences for stall/halt/reset, random traffic vs model.
module tb_mem_stage;
  localparam int AW = 8;

  localparam logic [5:0] T_LW    = 6'b100000;
  localparam logic [5:0] T_SW    = 6'b100001;
  localparam logic [5:0] T_BEQZ  = 6'b110100;
  localparam logic [5:0] T_BNEQZ = 6'b110101;
  localparam logic [5:0] T_HLT   = 6'b111111;

  logic          clk = 1'b0;
  logic          rst, in_valid, stall;
  logic [31:0]   NPC_ex, IR_ex, ALU_res, B_ex;
  logic          valid_mem, wb_en, halted;
  logic [31:0]   NPC_mem, IR_mem, ALU_mem, LMD, dbg_data;
  logic [4:0]    wb_rd;
  logic [AW-1:0] dbg_addr;

  int checks = 0;
  int errors = 0;

  mem_stage #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
    .NPC_ex(NPC_ex), .IR_ex(IR_ex), .ALU_res(ALU_res), .B_ex(B_ex),
    .valid_mem(valid_mem), .NPC_mem(NPC_mem), .IR_mem(IR_mem), .ALU_mem(ALU_mem),
    .LMD(LMD), .wb_en(wb_en), .wb_rd(wb_rd), .halted(halted),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_mem [256];
  logic        mem_known = 1'b0;
  logic        e_valid, e_wb_en, e_halted;
  logic [31:0] e_npc, e_ir, e_alu, e_lmd;
  logic [4:0]  e_wb_rd;
  logic        c_fields, c_wb;

  typedef struct {
    logic        r, v, s;
    logic [31:0] ir, alu, b, npc;
    logic [7:0]  da;
    logic        x_valid;
    logic [31:0] x_lmd;
    logic        x_wb_en;
    logic [4:0]  x_wb_rd;
    logic [31:0] x_alu;
    logic        x_halted;
    logic [31:0] x_dbg;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rs, rt, rd);
    return {op, rs, rt, rd, 11'h020};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mk(input logic [31:0] ir, alu, b, npc, input logic [7:0] da,
                              input logic xv, input logic [31:0] xl, input logic xw,
                              input logic [4:0] xr, input logic [31:0] xa, input logic [31:0] xd);
    vec_t t;
    t.r = 1'b0; t.v = 1'b1; t.s = 1'b0;
    t.ir = ir; t.alu = alu; t.b = b; t.npc = npc; t.da = da;
    t.x_valid = xv; t.x_lmd = xl; t.x_wb_en = xw; t.x_wb_rd = xr; t.x_alu = xa;
    t.x_halted = 1'b0; t.x_dbg = xd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behaviour at one clock edge, straight from the stage's rules.
  task automatic model_edge(input logic r, v, s, input logic [31:0] ir, alu, b, npc);
    logic [5:0] op;
    logic [7:0] idx;
    logic [4:0] dst;
    op  = ir[31:26];
    idx = alu[7:0];
    if (r) begin
      e_valid = 0; e_npc = 0; e_ir = 0; e_alu = 0; e_lmd = 0;
      e_wb_en = 0; e_wb_rd = 0; e_halted = 0; c_fields = 1; c_wb = 1;
    end else if (s) begin
      // everything holds
    end else if (e_halted) begin
      e_valid = 0; c_fields = 0; c_wb = 0;
    end else if (!v) begin
      e_valid = 0; e_wb_en = 0; e_lmd = 0; c_wb = 1; c_fields = 0;
    end else begin
      e_valid = 1; e_npc = npc; e_ir = ir; e_alu = alu; c_fields = 1; c_wb = 1;
      dst = 0; e_lmd = 0;
      case (op[5:4])
        2'b00: dst = ir[15:11];
        2'b01: dst = ir[20:16];
        default: begin
          if (op == T_LW) begin dst = ir[20:16]; e_lmd = m_mem[idx]; end
          else if (op == T_SW) m_mem[idx] = b;
          else if (op == T_HLT) e_halted = 1;
        end
      endcase
      e_wb_rd = dst;
      e_wb_en = (dst != 0);
    end
  endtask

  task automatic check_model();
    chk("valid_mem", valid_mem, e_valid);
    chk("halted", halted, e_halted);
    if (c_wb) begin
      chk("wb_en", wb_en, e_wb_en);
      chk("LMD", LMD, e_lmd);
    end
    if (c_fields) begin
      chk("NPC_mem", NPC_mem, e_npc);
      chk("IR_mem", IR_mem, e_ir);
      chk("ALU_mem", ALU_mem, e_alu);
      chk("wb_rd", wb_rd, e_wb_rd);
    end
    if (mem_known) begin
      dbg_addr = 8'($urandom);
      #1;
      chk("dbg_data_rand", dbg_data, m_mem[dbg_addr]);
    end
  endtask

  task automatic step(input logic r, v, s, input logic [31:0] ir, alu, b, npc);
    rst = r; in_valid = v; stall = s;
    IR_ex = ir; ALU_res = alu; B_ex = b; NPC_ex = npc;
    @(posedge clk);
    model_edge(r, v, s, ir, alu, b, npc);
    #1;
    check_model();
  endtask

  task automatic peek(input string name, input logic [7:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(name, dbg_data, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, valid_mem, 0);
    chk({tag, "_npc"}, NPC_mem, 0);
    chk({tag, "_ir"}, IR_mem, 0);
    chk({tag, "_alu"}, ALU_mem, 0);
    chk({tag, "_lmd"}, LMD, 0);
    chk({tag, "_wb_en"}, wb_en, 0);
    chk({tag, "_wb_rd"}, wb_rd, 0);
    chk({tag, "_halted"}, halted, 0);
  endtask

  initial begin
    logic [31:0] pre;
    rst = 1; in_valid = 0; stall = 0; dbg_addr = 0;
    NPC_ex = 0; IR_ex = 0; ALU_res = 0; B_ex = 0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, i_ins(T_SW, 0, 0, 0), 0, 0, 0);
    chk_all_zero("reset");

    for (int i = 0; i < 256; i++)
      step(0, 1, 0, i_ins(T_SW, 0, 0, 16'(i)), i, $urandom, 32'(i * 4));
    mem_known = 1'b1;

    tbl.push_back(mk(i_ins(T_SW, 1, 2, 16'h10), 32'h10, 32'hDEADBEEF, 32'h4, 8'h10,
                     1, 0, 0, 0, 32'h10, 32'hDEADBEEF));
    tbl.push_back(mk(i_ins(T_LW, 1, 5, 16'h10), 32'h10, 32'h0, 32'h8, 8'h10,
                     1, 32'hDEADBEEF, 1, 5, 32'h10, 32'hDEADBEEF));
    tbl.push_back(mk(i_ins(T_SW, 1, 2, 16'h110), 32'h110, 32'h1234, 32'hC, 8'h10,
                     1, 0, 0, 0, 32'h110, 32'h1234));
    tbl.push_back(mk(r_ins(6'b000000, 1, 2, 0), 32'd5, 32'h0, 32'h10, 8'h10,
                     1, 0, 0, 0, 32'd5, 32'h1234));
    tbl.push_back(mk(r_ins(6'b000000, 1, 2, 7), 32'd42, 32'h0, 32'h14, 8'h10,
                     1, 0, 1, 7, 32'd42, 32'h1234));
    tbl.push_back(mk(i_ins(6'b010000, 3, 9, 16'h7), 32'd99, 32'h0, 32'h18, 8'h10,
                     1, 0, 1, 9, 32'd99, 32'h1234));
    tbl.push_back(mk(i_ins(T_BEQZ, 4, 0, 16'h8), 32'h2C, 32'h0, 32'h30, 8'h10,
                     1, 0, 0, 0, 32'h2C, 32'h1234));
    tbl.push_back(mk(i_ins(T_LW, 1, 0, 16'h10), 32'h10, 32'h0, 32'h34, 8'h10,
                     1, 32'h1234, 0, 0, 32'h10, 32'h1234));
    begin
      vec_t t;
      t = mk(i_ins(T_LW, 1, 6, 16'h10), 32'h10, 32'h0, 32'h38, 8'h10,
             0, 0, 0, 0, 0, 32'h1234);
      t.v = 1'b0;
      tbl.push_back(t);
    end

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].ir, tbl[i].alu, tbl[i].b, tbl[i].npc);
      chk($sformatf("vec%0d_valid", i), valid_mem, tbl[i].x_valid);
      chk($sformatf("vec%0d_lmd", i), LMD, tbl[i].x_lmd);
      chk($sformatf("vec%0d_wb_en", i), wb_en, tbl[i].x_wb_en);
      chk($sformatf("vec%0d_halted", i), halted, tbl[i].x_halted);
      if (tbl[i].x_valid) begin
        chk($sformatf("vec%0d_wb_rd", i), wb_rd, tbl[i].x_wb_rd);
        chk($sformatf("vec%0d_alu", i), ALU_mem, tbl[i].x_alu);
      end
      peek($sformatf("vec%0d_dbg", i), tbl[i].da, tbl[i].x_dbg);
    end

    // Stall: SW held off for three cycles, then released once.
    step(0, 1, 0, r_ins(6'b000000, 1, 2, 7), 32'd42, 0, 32'h100);
    pre = m_mem[8'h20];
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, i_ins(T_SW, 0, 0, 16'h20), 32'h20, 32'hCAFEF00D, 32'h104);
      chk("stall_alu_hold", ALU_mem, 32'd42);
      chk("stall_rd_hold", wb_rd, 5'd7);
      chk("stall_valid_hold", valid_mem, 1);
      peek("stall_mem_hold", 8'h20, pre);
    end
    step(0, 1, 0, i_ins(T_SW, 0, 0, 16'h20), 32'h20, 32'hCAFEF00D, 32'h104);
    chk("unstall_alu", ALU_mem, 32'h20);
    peek("unstall_mem", 8'h20, 32'hCAFEF00D);
    step(0, 1, 0, i_ins(T_LW, 0, 3, 16'h20), 32'h20, 0, 32'h108);
    chk("unstall_load", LMD, 32'hCAFEF00D);

    // Halt: later SW is ignored until reset.
    step(0, 1, 0, {T_HLT, 26'h0}, 0, 0, 32'h200);
    chk("hlt_halted", halted, 1);
    chk("hlt_valid", valid_mem, 1);
    chk("hlt_wb_en", wb_en, 0);
    pre = m_mem[3];
    step(0, 1, 0, i_ins(T_SW, 0, 0, 16'h3), 32'h3, 32'h5555_5555, 32'h204);
    chk("halt_sticky", halted, 1);
    chk("halt_valid", valid_mem, 0);
    peek("halt_no_store", 8'd3, pre);
    step(1, 0, 0, 0, 0, 0, 0);
    chk_all_zero("halt_rst");

    // Reset in the same cycle as a store.
    step(0, 1, 0, r_ins(6'b000001, 1, 2, 9), 32'd77, 0, 32'h300);
    pre = m_mem[5];
    step(1, 1, 0, i_ins(T_SW, 0, 0, 16'h5), 32'h5, 32'h7777_7777, 32'h304);
    chk_all_zero("rst_sw");
    peek("rst_sw_no_store", 8'd5, pre);
    step(1, 1, 1, i_ins(T_SW, 0, 0, 16'h5), 32'h5, 32'h7777_7777, 32'h308);
    chk_all_zero("rst_over_stall");

    for (int n = 0; n < 800; n++) begin
      logic r, v, s;
      logic [31:0] ir, alu;
      int k;
      r = e_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 4) == 0);
      k = $urandom_range(0, 15);
      ir = $urandom;
      if (k < 4)       ir[31:26] = {2'b00, 4'($urandom)};
      else if (k < 6)  ir[31:26] = {2'b01, 4'($urandom)};
      else if (k < 9)  ir[31:26] = T_LW;
      else if (k < 12) ir[31:26] = T_SW;
      else if (k == 12) ir[31:26] = T_BEQZ;
      else if (k == 13) ir[31:26] = T_BNEQZ;
      else if (k == 14) ir[31:26] = {3'b101, 3'($urandom)};
      else ir[31:26] = ($urandom_range(0, 3) == 0) ? T_HLT : T_LW;
      alu = $urandom;
      if ($urandom_range(0, 1) == 1) alu[7:0] = 8'($urandom_range(0, 7));
      step(r, v, s, ir, alu, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
